// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder for the single-cycle core.
// Word-addressed RAM (combinational read, synchronous write), a post-reset
// zero-fill sequencer, and a small MMIO window (cycle counter, tohost, scratch).
module data_mem_responder #(
  parameter int                         WORD_BITWIDTH = 32,
  parameter int                         DEPTH_WORDS   = 1024,
  parameter logic [WORD_BITWIDTH-1:0]   MMIO_BASE     = 32'h1000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce_i,
  input  logic                     we_i,
  input  logic [WORD_BITWIDTH-1:0] addr_i,
  input  logic [WORD_BITWIDTH-1:0] wdata_i,
  output logic [WORD_BITWIDTH-1:0] rdata_o,
  output logic                     init_busy_o,
  output logic                     halt_o,
  output logic [WORD_BITWIDTH-1:0] exit_code_o,
  output logic                     err_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WORD_BITWIDTH-1:0] RAM_BYTES    = WORD_BITWIDTH'(DEPTH_WORDS * 4);
  localparam logic [WORD_BITWIDTH-1:0] ADDR_CYCLE   = MMIO_BASE;
  localparam logic [WORD_BITWIDTH-1:0] ADDR_TOHOST  = MMIO_BASE + WORD_BITWIDTH'(4);
  localparam logic [WORD_BITWIDTH-1:0] ADDR_SCRATCH = MMIO_BASE + WORD_BITWIDTH'(8);
  localparam logic [AW-1:0]            LAST_IDX     = AW'(DEPTH_WORDS - 1);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t                   r_state;
  logic [AW-1:0]            r_init_idx;
  logic [WORD_BITWIDTH-1:0] r_cycle;
  logic [WORD_BITWIDTH-1:0] r_scratch;
  logic [WORD_BITWIDTH-1:0] r_exit_code;
  logic                     r_halt;
  logic                     r_err;
  logic [WORD_BITWIDTH-1:0] r_mem [DEPTH_WORDS];

  logic                     w_misaligned;
  logic                     w_is_ram;
  logic                     w_is_cycle;
  logic                     w_is_tohost;
  logic                     w_is_scratch;
  logic                     w_unmapped;
  logic                     w_access_bad;
  logic                     w_wr_ok;
  logic [AW-1:0]            w_ram_idx;
  logic [WORD_BITWIDTH-1:0] w_rdata;

  // Address decode; RAM takes priority should the MMIO window ever overlap it.
  assign w_misaligned = (addr_i[1:0] != 2'b00);
  assign w_is_ram     = (addr_i < RAM_BYTES);
  assign w_is_cycle   = !w_is_ram && (addr_i == ADDR_CYCLE);
  assign w_is_tohost  = !w_is_ram && (addr_i == ADDR_TOHOST);
  assign w_is_scratch = !w_is_ram && (addr_i == ADDR_SCRATCH);
  assign w_unmapped   = !(w_is_ram || w_is_cycle || w_is_tohost || w_is_scratch);
  assign w_access_bad = w_misaligned || w_unmapped;
  assign w_ram_idx    = addr_i[AW+1:2];

  // Stores only take effect while running and only when word-aligned.
  assign w_wr_ok = we_i && !w_misaligned && (r_state == S_RUN);

  // Combinational load path; always shows pre-edge contents, so a same-cycle
  // store to the same address is only visible from the next cycle.
  always_comb begin
    w_rdata = '0;
    if (ce_i && (r_state != S_INIT) && !w_misaligned) begin
      if (w_is_ram)          w_rdata = r_mem[w_ram_idx];
      else if (w_is_cycle)   w_rdata = r_cycle;
      else if (w_is_tohost)  w_rdata = r_exit_code;
      else if (w_is_scratch) w_rdata = r_scratch;
      else                   w_rdata = '0;
    end
  end

  // Control FSM: zero-fill sequencing, cycle counter, MMIO registers, sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_INIT;
      r_init_idx  <= '0;
      r_cycle     <= '0;
      r_scratch   <= '0;
      r_exit_code <= '0;
      r_halt      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_init_idx <= r_init_idx + AW'(1);
          if (r_init_idx == LAST_IDX) r_state <= S_RUN;
        end
        S_RUN: begin
          r_cycle <= r_cycle + WORD_BITWIDTH'(1);
          if ((ce_i || we_i) && w_access_bad) r_err <= 1'b1;
          if (w_wr_ok && w_is_scratch) r_scratch <= wdata_i;
          if (w_wr_ok && w_is_tohost) begin
            r_halt      <= 1'b1;
            r_exit_code <= wdata_i;
            r_state     <= S_HALT;
          end
        end
        S_HALT: begin
          // Writes are silently dropped here; only bad loads still flag an error.
          if (ce_i && w_access_bad) r_err <= 1'b1;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  // RAM write port: the zero-fill owns the port during INIT, stores afterwards.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_mem[r_init_idx] <= '0;
    end else if (w_wr_ok && w_is_ram) begin
      r_mem[w_ram_idx] <= wdata_i;
    end
  end

  assign rdata_o     = w_rdata;
  assign init_busy_o = (r_state == S_INIT);
  assign halt_o      = r_halt;
  assign exit_code_o = r_exit_code;
  assign err_o       = r_err;

endmodule
